// File: rtl/send_uart_fmt.sv
// Sends each accepted byte as ASCII hex text on a UART line: two uppercase hex digits, then CR and LF.
// Each character is framed 8N1, with every bit held for CLK_HZ/BAUD clocks.
module send_uart_fmt #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_vld,
    input  logic [7:0] in_data,
    output logic       in_rdy,
    output logic       tx,
    output logic       busy
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [1:0]         char_q, char_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         data_q, data_d;
    logic               tx_q, tx_d;
    logic [7:0]         char_byte;
    logic               wrap;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
    endfunction

    always_comb begin
        case (char_q)
            2'd0:    char_byte = hex_ascii(data_q[7:4]);
            2'd1:    char_byte = hex_ascii(data_q[3:0]);
            2'd2:    char_byte = 8'h0D;
            default: char_byte = 8'h0A;
        endcase
    end

    assign wrap = (baud_q == CNT_W'(DIV - 1));

    // NOTE: each output of this block gets a default before the case, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        baud_d  = wrap ? '0 : baud_q + CNT_W'(1);
        char_d  = char_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (in_vld) begin
                    state_d = START;
                    data_d  = in_data;
                    char_d  = 2'd0;
                    bit_d   = 3'd0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (wrap) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = char_byte[0];
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = char_byte[bit_q + 3'd1];
                    end
                end
            end
            STOP: begin
                if (wrap) begin
                    if (char_q == 2'd3) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        // The next start bit follows the stop bit directly, with no idle gap.
                        state_d = START;
                        char_d  = char_q + 2'd1;
                        tx_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            char_q  <= 2'd0;
            bit_q   <= 3'd0;
            data_q  <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            char_q  <= char_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    assign in_rdy = (state_q == IDLE);
    assign busy   = ~in_rdy;
    assign tx     = tx_q;

endmodule

// File: tb/tb_send_uart_fmt.sv
// Bench for send_uart_fmt: a per-cycle compare against a frame-position model, plus a UART receiver.
// Decoded bytes are checked against hand-computed literals and against the randomly chosen data.
module tb_send_uart_fmt;

    localparam int CLK_HZ = 100000000;
    localparam int BAUD   = 1000000;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int FRAME  = 40 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_vld = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_rdy, tx, busy;

    int n_pass = 0;
    int n_total = 0;
    logic cmp_en = 1'b0;

    send_uart_fmt #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data),
        .in_rdy(in_rdy), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [7:0] hex_chr(input logic [3:0] n);
        return (n < 10) ? 8'd48 + 8'(n) : 8'd55 + 8'(n);
    endfunction

    // Line level at bit slot b (0..39) of the text frame for value v.
    function automatic logic frame_bit(input logic [7:0] v, input int b);
        int c = b / 10;
        int k = b % 10;
        logic [7:0] ch;
        case (c)
            0:       ch = hex_chr(v[7:4]);
            1:       ch = hex_chr(v[3:0]);
            2:       ch = 8'h0D;
            default: ch = 8'h0A;
        endcase
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return ch[k-1];
    endfunction

    // Model: position in the frame in clocks, or -1 when idle.
    int         m_pos = -1;
    logic [7:0] m_byte = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_pos <= -1;
        else if (m_pos < 0) begin
            if (in_vld) begin
                m_pos  <= 0;
                m_byte <= in_data;
            end
        end else if (m_pos == FRAME - 1) m_pos <= -1;
        else m_pos <= m_pos + 1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic m_tx;
            m_tx = (m_pos < 0) ? 1'b1 : frame_bit(m_byte, m_pos / DIV);
            check("cycle tx/rdy/busy", {61'd0, tx, in_rdy, busy},
                  {61'd0, m_tx, m_pos < 0, m_pos >= 0});
        end
    end

    // UART receiver that samples each bit at mid-bit.
    logic [7:0] rx_q[$];
    logic       rx_abort = 1'b0;

    always @(negedge rst_n) rx_abort = 1'b1;

    initial begin
        logic [7:0] b;
        logic       stop;
        forever begin
            @(negedge tx);
            rx_abort = 1'b0;
            repeat (DIV / 2) @(posedge clk);
            #1;
            if (tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(posedge clk);
                    #1;
                    b[i] = tx;
                end
                repeat (DIV) @(posedge clk);
                #1;
                stop = tx;
                if (!rx_abort && stop === 1'b1) rx_q.push_back(b);
            end
        end
    end

    task automatic wait_rdy(output int cycles);
        cycles = 0;
        while (in_rdy !== 1'b1 && cycles < 50000) begin
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 50000) check("in_rdy timeout", 64'd0, 64'd1);
    endtask

    task automatic check_rx(input string tag, input logic [63:0] exp, input int n);
        check({tag, " byte count"}, 64'(rx_q.size()), 64'(n));
        for (int i = 0; i < n; i++)
            if (i < rx_q.size())
                check($sformatf("%s byte %0d", tag, i), 64'(rx_q[i]), 64'(exp[8*(n-1-i) +: 8]));
    endtask

    initial begin
        int c;
        int edges;
        logic prev;
        logic [7:0] v;
        logic [63:0] exp;

        // Reset values
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset tx", 64'(tx), 64'd1);
        check("reset in_rdy", 64'(in_rdy), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        cmp_en = 1'b1;

        // 0x3A accepted on the first edge after reset release
        rst_n = 1'b1;
        in_vld = 1'b1;
        in_data = 8'h3A;
        @(negedge clk);
        in_vld = 1'b0;
        in_data = 8'h99;
        check("start bit latency", 64'(tx), 64'd0);
        wait_rdy(c);
        check("rdy low clocks 3A", 64'(c), 64'd4000);
        check_rx("3A", 64'h33_41_0D_0A, 4);
        rx_q.delete();

        // 0x00 then 0xFF back to back, in_vld held across the busy frame
        in_vld = 1'b1;
        in_data = 8'h00;
        @(negedge clk);
        in_data = 8'hFF;
        wait_rdy(c);
        check("rdy low clocks 00", 64'(c), 64'd4000);
        @(negedge clk);
        in_vld = 1'b0;
        check("b2b accept", 64'(in_rdy), 64'd0);
        wait_rdy(c);
        check("rdy low clocks FF", 64'(c), 64'd4000);
        check_rx("00/FF", 64'h30_30_0D_0A_46_46_0D_0A, 8);
        rx_q.delete();

        // 0x5C accepted, 0x11 offered mid-frame is ignored
        @(negedge clk);
        in_vld = 1'b1;
        in_data = 8'h5C;
        @(negedge clk);
        in_vld = 1'b0;
        repeat (499) @(negedge clk);
        in_vld = 1'b1;
        in_data = 8'h11;
        @(negedge clk);
        in_vld = 1'b0;
        wait_rdy(c);
        repeat (200) @(negedge clk);
        check("no capture while busy", 64'(in_rdy), 64'd1);
        check_rx("5C", 64'h35_43_0D_0A, 4);
        rx_q.delete();

        // Reset mid-frame aborts with tx high and stays quiet
        in_vld = 1'b1;
        in_data = 8'h3A;
        @(negedge clk);
        in_vld = 1'b0;
        repeat (1499) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort tx", 64'(tx), 64'd1);
        check("abort in_rdy", 64'(in_rdy), 64'd1);
        check("abort busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        prev = tx;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== prev) edges++;
            prev = tx;
        end
        check("tx edges after abort", 64'(edges), 64'd0);
        check_rx("aborted 3A", 64'h33, 1);
        rx_q.delete();

        // Random values with random idle gaps and junk requests during the frame
        for (int i = 0; i < 8; i++) begin
            v = 8'($urandom);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            in_vld = 1'b1;
            in_data = v;
            @(negedge clk);
            in_vld = 1'b0;
            in_data = 8'($urandom);
            repeat ($urandom_range(1, 3900)) @(negedge clk);
            in_vld = 1'b1;
            @(negedge clk);
            in_vld = 1'b0;
            wait_rdy(c);
            exp = {hex_chr(v[7:4]), hex_chr(v[3:0]), 8'h0D, 8'h0A};
            check_rx($sformatf("rand %0h", v), exp, 4);
            rx_q.delete();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/send_uart_fmt.md
SEND_UART_FMT -- requirements
Module: send_uart_fmt

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 1000000, UART bit rate; DIV = CLK_HZ/BAUD (integer, >= 2) clocks per bit.
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_vld  input  1  SEND result valid from the execute stage.
REQ-006 The block SHALL have port in_data  input  8  register value to transmit.
REQ-007 The block SHALL have port in_rdy  output  1  block idle and able to accept a value.
REQ-008 The block SHALL have port tx  output  1  UART serial line to RsTx, idle high.
REQ-009 The block SHALL have port busy  output  1  frame in progress (equals ~in_rdy).

Function
REQ-010 The block SHALL accept in_data on a rising clk edge where in_vld=1 and in_rdy=1; no other edge SHALL capture in_data.
REQ-011 in_rdy SHALL be 1 only in state IDLE; in_vld while busy SHALL be ignored, with no buffering and no effect on the frame in progress.
REQ-012 An accepted value SHALL be transmitted as four characters in order: ASCII hex of in_data[7:4], ASCII hex of in_data[3:0], 0x0D, 0x0A.
REQ-013 Hex digits SHALL map 0-9 to 0x30-0x39 and A-F to uppercase 0x41-0x46.
REQ-014 Each character SHALL be sent as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit held exactly DIV clocks.
REQ-015 There SHALL be no idle gap between characters; the next start bit SHALL directly follow the previous stop bit.
REQ-016 The FSM SHALL have states IDLE, START, DATA, STOP, with a 2-bit character index (0..3) and a 3-bit bit index (0..7).
REQ-017 Transitions: IDLE->START on accept; START->DATA after DIV clocks; DATA->STOP after bit 7 completes; STOP->START if char index < 3, else STOP->IDLE, each after DIV clocks.
REQ-018 tx SHALL be driven from a register; the start bit SHALL appear on tx in the first cycle after the accept edge.
REQ-019 The baud counter SHALL count 0..DIV-1 and wrap; a bit boundary SHALL occur on wrap only, and the counter SHALL clear on accept.
REQ-020 Total frame duration SHALL be 40*DIV clocks from the first start-bit cycle to the end of the final stop bit.
REQ-021 in_rdy SHALL assert in the cycle immediately following the last stop-bit cycle; a new accept SHALL be possible on that edge, giving back-to-back frames with no gap.
REQ-022 The captured value SHALL be held internally for the entire frame; changes on in_data during a frame SHALL NOT alter the transmitted characters.

Reset
REQ-023 rst_n=0 SHALL immediately (asynchronously) force state IDLE, all counters 0, tx=1, in_rdy=1, busy=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with tx high; no partial character SHALL resume after rst_n returns to 1.
REQ-025 The first accept SHALL be possible on the first rising clk edge after rst_n deasserts.

Verification
REQ-026 DIV=100, in_data=0x3A pulsed with in_vld -> UART decodes bytes 0x33,0x41,0x0D,0x0A; in_rdy low for exactly 4000 clocks.
REQ-027 in_data=0x00, then in_data=0xFF on the cycle in_rdy returns -> bytes 30 30 0D 0A 46 46 0D 0A with no idle cycle between the frames.
REQ-028 in_data=0x5C accepted, then in_vld=1 with 0x11 at clock 500 of the frame -> only 35 43 0D 0A is transmitted, and 0x11 is never sent.
REQ-029 rst_n pulsed low at clock 1500 of the 0x3A frame -> tx=1 within the same cycle, in_rdy=1, and no further tx transitions until a new accept.
REQ-030 Bit-timing check: every tx level persists a multiple of DIV clocks, and the start-bit falling edge comes exactly 1 clock after the accept edge.
